// File: rtl/mem_bus_unit_pkg.sv
// Shared encodings for the MEM-stage bus front end: ops, ExcCodes, FSM states, default address map.
package mem_bus_unit_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bus_state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  localparam logic [31:0] DEF_DATA_BASE  = 32'h0000_0000;
  localparam logic [31:0] DEF_DATA_LIMIT = 32'h0000_2FFF;
  localparam logic [31:0] DEF_IO_BASE    = 32'h0000_7F00;
  localparam logic [31:0] DEF_IO_STRIDE  = 32'h0000_0010;

  function automatic logic op_is_store(mem_op_e op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane logic shared by the store path (enables, data shift) and load path (extract/extend).
module mem_lane_align
  import mem_bus_unit_pkg::*;
(
  input  mem_op_e     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [15:0] half;
  logic [31:0] rsh;
  logic [7:0]  byt;

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    half    = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    rsh     = rdata_i >> {off_i, 3'b000};
    byt     = rsh[7:0];
    case (op_i)
      OP_LW:  rdata_o = rdata_i;
      OP_LH:  rdata_o = {{16{half[15]}}, half};
      OP_LHU: rdata_o = {16'h0000, half};
      OP_LB:  rdata_o = {{24{byt[7]}}, byt};
      OP_LBU: rdata_o = {24'h000000, byt};
      OP_SW: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
      OP_SH: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = off_i[1] ? {wdata_i[15:0], 16'h0000} : {16'h0000, wdata_i[15:0]};
      end
      OP_SB: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {24'h000000, wdata_i[7:0]} << {off_i, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_unit.sv
// MEM-stage load/store to valid/ack bus bridge with stall, lane alignment and AdEL/AdES/DBE classification.
// Optional WAIT timeout enabled by defining MEM_TIMEOUT_EN.
module mem_bus_unit
  import mem_bus_unit_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DEF_DATA_BASE,
  parameter logic [31:0] DATA_LIMIT  = DEF_DATA_LIMIT,
  parameter logic [31:0] IO_BASE     = DEF_IO_BASE,
  parameter int          IO_CHANNELS = 2,
  parameter logic [31:0] IO_STRIDE   = DEF_IO_STRIDE,
  parameter int          IO_SPAN     = 12,
  parameter int          IO_RO_OFF   = 8,
  parameter int          TIMEOUT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic        kill,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [4:0]  resp_exc,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [31:0] bus_pc,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  if (IO_CHANNELS < 1 || IO_CHANNELS > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_bus_unit: IO_CHANNELS must be 1..8 and TIMEOUT >= 1");
  end

  bus_state_e  state_q;
  mem_op_e     op_q;
  logic [1:0]  off_q;
  logic        kill_q;
  logic [31:0] rdata_q;
  logic [4:0]  exc_q;
  logic        bus_req_q;
  logic [3:0]  bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, bus_pc_q;

  mem_op_e     req_op_e, op_sel;
  logic [1:0]  off_sel;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  logic [31:0] io_off;
  logic        in_data, in_io, in_ro, is_store, misalign, outside;
  logic [4:0]  req_exc;
  logic        accept, issue, tmo_hit;

  assign req_op_e = mem_op_e'(req_op);
  assign in_data  = (req_addr - DATA_BASE) <= (DATA_LIMIT - DATA_BASE);

  always_comb begin
    io_off   = '0;
    in_io    = 1'b0;
    in_ro    = 1'b0;
    for (int i = 0; i < IO_CHANNELS; i++) begin
      io_off = req_addr - (IO_BASE + IO_STRIDE * 32'(i));
      if (io_off < 32'(IO_SPAN)) in_io = 1'b1;
      if (io_off[31:2] == 30'(IO_RO_OFF / 4)) in_ro = 1'b1;
    end
    is_store = op_is_store(req_op_e);
    misalign = ((req_op_e == OP_LW || req_op_e == OP_SW) && req_addr[1:0] != 2'b00) ||
               ((req_op_e == OP_LH || req_op_e == OP_LHU || req_op_e == OP_SH) && req_addr[0]);
    // Sub-word accesses are only defined on RAM; IO windows are word registers.
    outside  = (req_op_e == OP_LW || req_op_e == OP_SW) ? !(in_data || in_io) : !in_data;
    req_exc  = EXC_NONE;
    if (misalign || outside || (is_store && in_ro)) req_exc = is_store ? EXC_ADES : EXC_ADEL;
  end

  assign accept = (state_q == IDLE) && req_valid && !kill;
  assign issue  = accept && (req_exc == EXC_NONE);

  assign op_sel  = (state_q == IDLE) ? req_op_e : op_q;
  assign off_sel = (state_q == IDLE) ? req_addr[1:0] : off_q;

  mem_lane_align u_lane (
    .op_i    (op_sel),
    .off_i   (off_sel),
    .wdata_i (req_wdata),
    .rdata_i (bus_rdata),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                tmo_cnt_q <= '0;
    else if (state_q == WAIT)  tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else                       tmo_cnt_q <= '0;
  end

  assign tmo_hit = (state_q == WAIT) && (tmo_cnt_q == TW'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_LW;
      off_q       <= 2'b00;
      kill_q      <= 1'b0;
      rdata_q     <= '0;
      exc_q       <= EXC_NONE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 4'b0000;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q     <= WAIT;
            op_q        <= req_op_e;
            off_q       <= req_addr[1:0];
            kill_q      <= 1'b0;
            bus_req_q   <= 1'b1;
            bus_we_q    <= lane_be;
            bus_addr_q  <= {req_addr[31:2], 2'b00};
            bus_wdata_q <= lane_wdata;
            bus_pc_q    <= req_pc;
          end
        end
        WAIT: begin
          // A killed access still runs to ack so the slave sees a complete handshake.
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            rdata_q   <= lane_rdata;
            exc_q     <= bus_err ? EXC_DBE : EXC_NONE;
            state_q   <= (kill_q || kill) ? IDLE : DONE;
          end else if (tmo_hit) begin
            bus_req_q <= 1'b0;
            rdata_q   <= '0;
            exc_q     <= EXC_DBE;
            state_q   <= (kill_q || kill) ? IDLE : DONE;
          end else if (kill) begin
            kill_q <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = issue || (state_q == WAIT);
  assign resp_valid = (accept && (req_exc != EXC_NONE)) || (state_q == DONE);
  assign resp_exc   = (state_q == DONE) ? exc_q : (accept ? req_exc : EXC_NONE);
  assign resp_rdata = (state_q == DONE) ? rdata_q : '0;

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_pc    = bus_pc_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Directed bench for mem_bus_unit: expected responses queued at drive time, checked when resp_valid fires.
module tb_mem_bus_unit;
  import mem_bus_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, kill;
  logic [2:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        stall, resp_valid, bus_req, bus_ack, bus_err;
  logic [31:0] resp_rdata, bus_addr, bus_wdata, bus_pc, bus_rdata;
  logic [4:0]  resp_exc;
  logic [3:0]  bus_we;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  exc;
  } exp_t;
  exp_t sb_q[$];

  int compared = 0;
  int mismatched = 0;

  int          sl_delay = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err = 1'b0;
  bit          hold_ack = 1'b0;
  int          wcnt = 0;
  logic [31:0] pc_ctr = 32'h0040_0000;

  always #5 clk = ~clk;

  mem_bus_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc), .kill(kill),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_exc(resp_exc),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_pc(bus_pc), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  // Slave: acks on the (sl_delay+1)-th cycle bus_req is seen high.
  initial begin
    bus_ack = 1'b0; bus_rdata = '0; bus_err = 1'b0;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_err = 1'b0;
      if (bus_req && !hold_ack) begin
        if (wcnt == sl_delay) begin
          bus_ack = 1'b1; bus_rdata = sl_rdata; bus_err = sl_err; wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string name, input mem_op_e op, input logic [31:0] addr,
                     input logic [31:0] wd, input int dly, input logic [31:0] rd, input logic err,
                     input bit exp_bus, input logic [3:0] exp_we, input logic [31:0] exp_wd,
                     input logic [31:0] exp_rdata, input logic [4:0] exp_exc, input int exp_stall);
    int   stalls;
    bit   got, seen_bus;
    exp_t e;
    logic [31:0] pc;
    stalls = 0; got = 0; seen_bus = 0;
    sl_delay = dly; sl_rdata = rd; sl_err = err;
    pc = pc_ctr; pc_ctr += 32'd4;
    e.rdata = exp_rdata; e.exc = exp_exc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_pc = pc;
    for (int cyc = 0; cyc < 40 && !got; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (stall) stalls++;
      if (bus_req && !seen_bus) begin
        seen_bus = 1;
        check({name, "_we"}, 32'(bus_we), 32'(exp_we));
        check({name, "_addr"}, bus_addr, {addr[31:2], 2'b00});
        check({name, "_pc"}, bus_pc, pc);
        if (op_is_store(op)) check({name, "_wdata"}, bus_wdata, exp_wd);
      end
      if (resp_valid) begin
        got = 1;
        check({name, "_sbq"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check({name, "_rdata"}, resp_rdata, e.rdata);
          check({name, "_exc"}, 32'(resp_exc), 32'(e.exc));
        end
      end
    end
    check({name, "_got_resp"}, 32'(got), 32'd1);
    if (!got) sb_q.delete();
    check({name, "_bus_seen"}, 32'(seen_bus), 32'(exp_bus));
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stall));
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check({name, "_no_reissue"}, 32'(bus_req), 32'd0);
  endtask

  initial begin
    int  stalls;
    bit  saw;
    reset = 1'b0; req_valid = 1'b0; kill = 1'b0; req_op = 3'd0;
    req_addr = '0; req_wdata = '0; req_pc = '0;
    #12;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_bus_pc", bus_pc, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_exc", 32'(resp_exc), 32'd0);
    @(negedge clk); reset = 1'b1;

    //   name       op      addr           wdata          dly rd             err  bus we       wdata          rdata          exc       stalls
    txn("lw10",     OP_LW,  32'h0000_0010, 32'h0,         2,  32'hDEAD_BEEF, 1'b0, 1, 4'b0000, 32'h0,         32'hDEAD_BEEF, EXC_NONE, 4);
    txn("sb13",     OP_SB,  32'h0000_0013, 32'h0000_00A5, 0,  32'h0,         1'b0, 1, 4'b1000, 32'hA500_0000, 32'h0,         EXC_NONE, 2);
    txn("lh06",     OP_LH,  32'h0000_0006, 32'h0,         1,  32'h8001_1234, 1'b0, 1, 4'b0000, 32'h0,         32'hFFFF_8001, EXC_NONE, 3);
    txn("lbu06",    OP_LBU, 32'h0000_0006, 32'h0,         0,  32'h8001_1234, 1'b0, 1, 4'b0000, 32'h0,         32'h0000_0001, EXC_NONE, 2);
    txn("lb05",     OP_LB,  32'h0000_0005, 32'h0,         0,  32'h0000_8000, 1'b0, 1, 4'b0000, 32'h0,         32'hFFFF_FF80, EXC_NONE, 2);
    txn("lhu2ffe",  OP_LHU, 32'h0000_2FFE, 32'h0,         1,  32'hC3A5_0000, 1'b0, 1, 4'b0000, 32'h0,         32'h0000_C3A5, EXC_NONE, 3);
    txn("sh02",     OP_SH,  32'h0000_0002, 32'h1234_BEEF, 0,  32'h0,         1'b0, 1, 4'b1100, 32'hBEEF_0000, 32'h0,         EXC_NONE, 2);
    txn("sw7f04",   OP_SW,  32'h0000_7F04, 32'h1234_5678, 1,  32'h0,         1'b0, 1, 4'b1111, 32'h1234_5678, 32'h0,         EXC_NONE, 3);
    txn("lw7f18e",  OP_LW,  32'h0000_7F18, 32'h0,         0,  32'h0,         1'b1, 1, 4'b0000, 32'h0,         32'h0,         EXC_DBE,  2);
    txn("lw102",    OP_LW,  32'h0000_0102, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADEL, 0);
    txn("sw7f18",   OP_SW,  32'h0000_7F18, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADES, 0);
    txn("lh7f00",   OP_LH,  32'h0000_7F00, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADEL, 0);
    txn("lw3000",   OP_LW,  32'h0000_3000, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADEL, 0);
    txn("sw7f0c",   OP_SW,  32'h0000_7F0C, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADES, 0);
    txn("lw7f20",   OP_LW,  32'h0000_7F20, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADEL, 0);
    txn("sh01",     OP_SH,  32'h0000_0001, 32'h0,         0,  32'h0,         1'b0, 0, 4'b0000, 32'h0,         32'h0,         EXC_ADES, 0);

    // kill in IDLE: neither a legal nor an illegal request may respond or stall
    @(negedge clk);
    req_valid = 1'b1; kill = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0040;
    #1;
    check("kidle_stall", 32'(stall), 32'd0);
    check("kidle_resp_legal", 32'(resp_valid), 32'd0);
    req_addr = 32'h0000_0041;
    #1;
    check("kidle_resp_illegal", 32'(resp_valid), 32'd0);
    @(negedge clk); req_valid = 1'b0; kill = 1'b0;
    #1;
    check("kidle_no_bus", 32'(bus_req), 32'd0);

    // kill in WAIT: access completes on the bus, response suppressed
    sl_delay = 2; sl_rdata = 32'h5555_AAAA; sl_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_LW; req_addr = 32'h0000_0020;
    #1;
    check("kwait_issue_stall", 32'(stall), 32'd1);
    @(negedge clk);
    kill = 1'b1; req_valid = 1'b0;
    #1;
    check("kwait_bus_req", 32'(bus_req), 32'd1);
    check("kwait_stall", 32'(stall), 32'd1);
    check("kwait_resp0", 32'(resp_valid), 32'd0);
    @(negedge clk); kill = 1'b0;
    saw = 0; stalls = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (resp_valid) saw = 1;
      if (stall) stalls++;
    end
    check("kwait_no_resp", 32'(saw), 32'd0);
    check("kwait_stalls", 32'(stalls), 32'd2);
    check("kwait_idle_req", 32'(bus_req), 32'd0);
    check("kwait_idle_stall", 32'(stall), 32'd0);

    // reset during WAIT drops bus_req without a clock edge
    hold_ack = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0000_0080; req_wdata = 32'h1;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    check("rwait_req_before", 32'(bus_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rwait_req_async", 32'(bus_req), 32'd0);
    check("rwait_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b1; hold_ack = 1'b0;
    #1;
    check("rwait_after_req", 32'(bus_req), 32'd0);
    txn("lw_recover", OP_LW, 32'h0000_0084, 32'h0, 0, 32'h0BAD_F00D, 1'b0, 1, 4'b0000, 32'h0, 32'h0BAD_F00D, EXC_NONE, 2);

`ifdef MEM_TIMEOUT_EN
    hold_ack = 1'b1;
    txn("lw_tmo", OP_LW, 32'h0000_0044, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 1, 4'b0000, 32'h0, 32'h0, EXC_DBE, 17);
    hold_ack = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
